// File: rtl/ntt_coeff_loader.sv
// Coefficient input stage for the ntt core: reduces each streamed sample mod Q
// and packs D of them into the flat a bus, held until the consumer acks.
module ntt_coeff_loader #(
    parameter int N = 9,
    parameter int D = 8,
    parameter int Q = 257
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_coeff,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [D*N-1:0]       a,
    output logic                 a_valid,
    input  logic                 a_ack,
    output logic [$clog2(D)-1:0] fill_cnt
);

    localparam int CW = $clog2(D);
    localparam logic [N:0] QW = (N+1)'(Q);

    typedef enum logic {FILL, FULL} state_t;

    state_t       state;
    logic [N:0]   diff;
    logic [N-1:0] r;
    logic         xfer;

    // Borrow out of the N+1-bit subtract is set exactly when in_coeff < Q.
    always_comb begin
        diff = {1'b0, in_coeff} - QW;
        r    = diff[N] ? in_coeff : diff[N-1:0];
    end

    assign in_ready = (state == FILL) && !rst;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            fill_cnt <= '0;
            a        <= '0;
            a_valid  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (xfer) begin
                        a[fill_cnt*N +: N] <= r;
                        fill_cnt           <= fill_cnt + 1'b1;
                        if (fill_cnt == CW'(D-1)) begin
                            state   <= FULL;
                            a_valid <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (a_ack) begin
                        state   <= FILL;
                        a_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= FILL;
                    a_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_coeff_loader.sv
// Randomized and directed bench for ntt_coeff_loader against a slot-array
// reference model of the fill/full behaviour.
module tb_ntt_coeff_loader;

    localparam int N  = 9;
    localparam int D  = 8;
    localparam int Q  = 257;
    localparam int CW = $clog2(D);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    in_coeff = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [D*N-1:0]  a;
    logic            a_valid;
    logic            a_ack = 1'b0;
    logic [CW-1:0]   fill_cnt;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    // reference model
    bit          m_full = 1'b0;
    int unsigned m_cnt  = 0;
    int unsigned ms[D];

    ntt_coeff_loader #(.N(N), .D(D), .Q(Q)) dut (
        .clk(clk), .rst(rst), .in_coeff(in_coeff), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .a_valid(a_valid), .a_ack(a_ack),
        .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [D*N-1:0] model_bus();
        logic [D*N-1:0] e;
        e = '0;
        for (int i = 0; i < D; i++) e[i*N +: N] = ms[i][N-1:0];
        return e;
    endfunction

    // One clock: drive, check ready before the edge, update model, check state after.
    task automatic cyc(input bit r, input bit v, input int unsigned c, input bit k, output bit acc);
        rst = r; in_valid = v; in_coeff = c[N-1:0]; a_ack = k;
        #1;
        chk("in_ready", in_ready, (!r && !m_full));
        @(posedge clk);
        acc = 1'b0;
        if (r) begin
            m_full = 1'b0; m_cnt = 0;
            for (int i = 0; i < D; i++) ms[i] = 0;
        end else if (m_full) begin
            if (k) m_full = 1'b0;
        end else if (v) begin
            ms[m_cnt] = c % Q;
            acc = 1'b1;
            m_cnt++;
            if (m_cnt == D) begin
                m_cnt = 0;
                m_full = 1'b1;
            end
        end
        #1;
        chk("a", a, model_bus());
        chk("a_valid", a_valid, m_full);
        chk("fill_cnt", fill_cnt, m_cnt);
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int unsigned red_in[D]  = '{0, 256, 257, 300, 511, 1, 2, 3};
        int unsigned red_exp[D] = '{0, 256, 0, 43, 254, 1, 2, 3};
        logic [D*N-1:0] e;
        logic [D*N-1:0] held;
        int unsigned pend, sent, pulses, budget;
        bit pend_v;

        @(negedge clk);
        cyc(1, 0, 0, 0, acc);
        cyc(1, 1, 3, 1, acc);
        chk("reset_a", a, 0);

        // basic fill with ones
        for (int i = 0; i < D; i++) cyc(0, 1, 1, 0, acc);
        e = '0;
        for (int i = 0; i < D; i++) e[i*N +: N] = N'(1);
        chk("ones_bus", a, e);
        chk("ones_valid", a_valid, 1);

        // hold FULL 20 cycles with a pending sample
        held = a;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 77, 0, acc);
            chk("hold_acc", acc, 0);
        end
        chk("hold_bus", a, held);

        // ack with simultaneous input
        cyc(0, 1, 5, 1, acc);
        chk("ackin_valid", a_valid, 0);
        chk("ackin_ready", in_ready, 1);
        cyc(0, 1, 5, 0, acc);
        chk("ackin_slot0", a[N-1:0], 5);
        chk("ackin_cnt", fill_cnt, 1);

        // reduction vector into a clean polynomial
        cyc(1, 0, 0, 0, acc);
        for (int i = 0; i < D; i++) cyc(0, 1, red_in[i], 0, acc);
        e = '0;
        for (int i = 0; i < D; i++) e[i*N +: N] = red_exp[i][N-1:0];
        chk("reduce_bus", a, e);
        cyc(0, 0, 0, 1, acc);

        // reset mid-fill, then a clean reload
        for (int i = 0; i < 5; i++) cyc(0, 1, 100 + i, 0, acc);
        cyc(1, 1, 9, 0, acc);
        chk("midrst_cnt", fill_cnt, 0);
        chk("midrst_a", a, 0);
        for (int i = 0; i < D; i++) cyc(0, 1, 20 + i, 0, acc);
        chk("reload_slot0", a[N-1:0], 20);
        chk("reload_slot7", a[(D-1)*N +: N], 20 + D - 1);

        // reset while FULL with ack
        cyc(1, 0, 0, 1, acc);
        chk("fullrst_valid", a_valid, 0);
        chk("fullrst_a", a, 0);

        // back-to-back polynomials, ack tied high
        sent = 0; pulses = 0; budget = 0;
        while (sent < 3*D && budget < 60) begin
            cyc(0, 1, 10 + sent, 1, acc);
            if (acc) sent++;
            if (a_valid) begin
                e = '0;
                for (int i = 0; i < D; i++) e[i*N +: N] = N'(10 + pulses*D + i);
                chk("b2b_poly", a, e);
                pulses++;
            end
            budget++;
        end
        chk("b2b_sent", sent, 3*D);
        chk("b2b_pulses", pulses, 3);
        cyc(0, 0, 0, 1, acc);

        // randomized traffic with a held-until-accepted source
        pend_v = 1'b0; pend = 0;
        for (int n = 0; n < 600; n++) begin
            if (!pend_v && ($urandom_range(0, 3) != 0)) begin
                pend_v = 1'b1;
                pend = $urandom_range(0, (1 << N) - 1);
            end
            cyc(($urandom_range(0, 63) == 0), pend_v, pend, ($urandom_range(0, 2) == 0), acc);
            if (acc) pend_v = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ntt_coeff_loader.md
# ntt_coeff_loader

Input stage for the combinational `ntt` core. Accepts polynomial coefficients one per cycle over a valid/ready stream and reduces each modulo Q. Packs D coefficients into the flat `a` bus in the layout `ntt` expects, then holds the bus stable with `a_valid` until the consumer acknowledges. Sits directly upstream of `ntt`: `a` connects straight to `ntt.a`.

## Interface
- `N`, 9: coefficient width in bits (matches `ntt` N).
- `D`, 8: coefficients per polynomial (matches `ntt` D); power of two, ≥ 2.
- `Q`, 257: modulus.
  - Constraint: 2^(N-1) < Q < 2^N, so one conditional subtract fully reduces any N-bit input.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_coeff`  input  N  coefficient sample, unsigned.
- `in_valid`  input  1  `in_coeff` is valid this cycle.
- `in_ready`  output  1  loader accepts a sample this cycle.
  - Transfer occurs when `in_valid && in_ready`.
- `a`  output  D*N  packed reduced coefficients.
  - Coefficient i occupies bits [N*(i+1)-1 : N*i].
  - Coefficient 0 is the first sample received.
- `a_valid`  output  1  `a` holds a complete polynomial.
- `a_ack`  input  1  consumer has taken `a`; only honoured while `a_valid`=1.
- `fill_cnt`  output  clog2(D)  number of coefficients stored in the current polynomial (0..D-1 while FILL).

## Operation
- Two states: FILL and FULL. Both `a_valid` and `in_ready` are registered or state-derived; no combinational path from `in_valid` to `in_ready`.
- Reduction: r = (in_coeff >= Q) ? in_coeff - Q : in_coeff, computed in N+1 bits and stored as N bits.
  - With default parameters, 256→256, 257→0, 511→254.
- FILL:
  - `in_ready` = 1 (forced 0 while `rst`=1).
  - On transfer: write r to slot `fill_cnt`, then increment `fill_cnt`.
  - Transfer with `fill_cnt` = D-1: slot D-1 is written, `fill_cnt` wraps to 0, next state is FULL.
  - `in_valid`=0: no change.
  - `a_ack` is ignored in FILL.
- FULL:
  - `a_valid` = 1 and `in_ready` = 0.
  - `a` is frozen and bit-stable.
  - `a_ack`=1: next state is FILL. `a` keeps its old contents until overwritten slot by slot.
  - Samples presented during FULL are not accepted; the upstream must hold them.
- `a_ack` and `in_valid` both high in FULL: ack is taken, the sample is not accepted that cycle, and it is accepted on the next cycle (FILL).
- Reset at any time, including mid-fill or while FULL:
  - Any partial polynomial is discarded and `a_ack` is ignored.
  - State → FILL, `fill_cnt` → 0, `a` → 0, `a_valid` → 0.

## Timing
- Reset values, visible after the first edge with `rst`=1: `a`=0, `a_valid`=0, `fill_cnt`=0. `in_ready`=0 during reset and 1 in the first cycle after `rst` falls.
- Each accepted sample appears in `a` on the edge that accepts it.
- Latency: if the D-th sample is accepted at edge k, `a_valid` is 1 from edge k onward, i.e. 1 cycle after that sample was presented.
- `a_valid` falls and `in_ready` rises at the edge where `a_ack`=1 is sampled.
- Maximum throughput is one polynomial per D+1 cycles (D fill cycles plus at least 1 FULL cycle).
- `ntt` is combinational, so `an` is valid whenever `a_valid`=1. The consumer may assert `a_ack` in the first FULL cycle.

## Test plan
- Basic fill: reset, then feed 1,1,…,1 (D=8) with `in_valid` held high.
  - `in_ready` high for 8 cycles.
  - `a_valid` rises after the 8th transfer; `a` = eight packed 9'd1.
  - `ntt` output checked against the known all-ones transform.
- Reduction: feed 0, 256, 257, 300, 511, 1, 2, 3.
  - Slots hold 0, 256, 0, 43, 254, 1, 2, 3 at the correct bit positions.
- Stall/backpressure:
  - Toggle `in_valid` randomly during fill: `fill_cnt` advances only on transfers.
  - Hold `a_ack`=0 for 20 cycles in FULL: `a` unchanged, `in_ready`=0, pending upstream sample not consumed.
- Ack with simultaneous input: in FULL, assert `a_ack`=1 and `in_valid`=1 with `in_coeff`=5.
  - Next cycle: FILL, `a_valid`=0, `in_ready`=1.
  - Sample 5 is accepted that cycle into slot 0.
- Reset mid-operation:
  - Assert `rst` after 5 transfers: `fill_cnt`=0, `a`=0, and the next full polynomial loads cleanly from slot 0.
  - Assert `rst` while FULL with `a_ack`=1: `a_valid`=0 and `a`=0.
- Back-to-back polynomials:
  - Stream 3×8 samples with `a_ack` tied high.
  - `a_valid` pulses 1 cycle per polynomial; each `a` matches its 8 inputs; no sample is lost or duplicated.
